fsm_6s2i2o_mo_stepper: RTL and testbench
========================================

FSM_6S2I2O_MO_STEPPER -- requirements
Module: fsm_6s2i2o_mo_stepper

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port step_val, input, 1 bit: when 1, the block advances the FSM one transition using in_ this cycle.
REQ-004 SHALL have port in_, input, 2 bits: FSM input, sampled only when step_val=1.
REQ-005 SHALL have port load_en, input, 1 bit: when 1, forces state to load_state this cycle.
REQ-006 SHALL have port load_state, input, 3 bits: state to load; any value 0-7 is legal, including invalid 6 and 7.
REQ-007 SHALL have port state, output, 3 bits: registered current state.
REQ-008 SHALL have ports out0 and out1, output, 1 bit each: Moore outputs decoded from registered state.
REQ-009 SHALL have port out_val, output, 1 bit: pulses for exactly one cycle after each accepted step or load.
REQ-010 SHALL have port trans_count, output, 8 bits: saturating count of accepted steps that changed state.
REQ-011 SHALL have port err, output, 1 bit: sticky flag, set when state holds 6 or 7.

Function
REQ-012 SHALL encode states as A=0, B=1, C=2, D=3, E=4, F=5.
REQ-013 SHALL use the following next-state table, with entries for in_=00/01/10/11: A->A/B/A/E; B->C/B/A/E; C->A/D/A/E; D->C/B/A/E; E->F/F/A/E; F->A/A/A/A.
REQ-014 SHALL decode outputs {out0,out1} as: A,B,C = 00; D = 10; E,F = 11.
REQ-015 SHALL set next state to A for any step taken from invalid state 6 or 7.
REQ-016 SHALL drive out0=0 and out1=0 while state is 6 or 7.
REQ-017 SHALL update state one cycle after an accepted step, giving a latency of one edge; outputs change in the same cycle as state.
REQ-018 SHALL give load_en priority over step_val when both are 1; in that case the step is discarded and trans_count does not change.
REQ-019 SHALL hold state, outputs and trans_count when step_val=0 and load_en=0.
REQ-020 SHALL increment trans_count only when state_next differs from state; self-loops do not count.
REQ-021 SHALL saturate trans_count at 255 with no wrap-around.
REQ-022 SHALL set err on the edge that makes state 6 or 7.
REQ-023 SHALL clear err only on reset; recovering to a valid state does not clear it.
REQ-024 SHALL drive out_val=1 in the cycle after any accepted step or load, including self-loops.

Reset
REQ-025 SHALL, on reset assertion and regardless of clk, force state=A, out0=0, out1=0, out_val=0, trans_count=0 and err=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard any step or load presented in that cycle.
REQ-027 SHALL accept the first step on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL, when FSM_STEPPER_CNT_EN is defined, implement trans_count as specified.
REQ-029 SHALL, when FSM_STEPPER_CNT_EN is undefined, tie trans_count to constant 0, include no counter register, and leave all other behaviour unchanged.

Structure
REQ-030 SHALL place the state encoding typedef (A-F), the constants NUM_STATES=6 and STATE_W=3, and the reset state in the shared package fsm_stepper_pkg.
REQ-031 SHALL place the pure combinational next-state and output table in one sub-module, fsm_6s2i2o_mo_tbl_logic (inputs state and in_; outputs state_next, out0 and out1); the top module holds only registers, load/step muxing, the counter and err.

Verification
REQ-032 SHALL cover table sweep: load each state 0-5, then step once with each in_ 00-11 -> state matches REQ-013, outputs match REQ-014, out_val=1 one cycle later.
REQ-033 SHALL cover sequence from reset: steps with in_=01,00,01 -> state B,C,D; {out0,out1}=10 at D; trans_count=3.
REQ-034 SHALL cover invalid recovery: load 6, then step with in_=11 -> err=1, outputs 00 while in 6, then state=A with err still 1; repeat the check with load 7.
REQ-035 SHALL cover priority: load_en=1 with load_state=4 and step_val=1 with in_=01 in the same cycle from A -> state=E, trans_count unchanged.
REQ-036 SHALL cover saturation: 300 alternating A/B steps (in_=01,10) -> trans_count=255; self-loop steps at A with in_=00 -> count does not change.
REQ-037 SHALL cover asynchronous reset: assert reset mid-cycle while in E -> state=A, trans_count=0 and err=0 before the next edge; with FSM_STEPPER_CNT_EN undefined, trans_count stays 0 throughout.

Source files
------------

// File: rtl/fsm_stepper_pkg.sv
// Shared state encoding and sizing for the 6-state Moore stepper.
// FSM_STEPPER_CNT_EN enables the trans_count register in the top.
package fsm_stepper_pkg;

  localparam int NUM_STATES = 6;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_A = 3'd0,
    S_B = 3'd1,
    S_C = 3'd2,
    S_D = 3'd3,
    S_E = 3'd4,
    S_F = 3'd5
  } state_e;

  localparam state_e RESET_STATE = S_A;

  function automatic logic is_invalid(
    input logic [STATE_W-1:0] s
  );
    return s >= STATE_W'(NUM_STATES);
  endfunction

endpackage

// File: rtl/fsm_6s2i2o_mo_stepper_tbl.sv
// Pure combinational next-state and Moore output table.
// Encodings 6 and 7 step to A and decode to 00.
module fsm_6s2i2o_mo_tbl_logic
  import fsm_stepper_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [1:0]         in_,
  output logic [STATE_W-1:0] state_next,
  output logic               out0,
  output logic               out1
);

  always_comb begin
    state_next = RESET_STATE;
    case (state)
      S_A: case (in_)
        2'b01:   state_next = S_B;
        2'b11:   state_next = S_E;
        default: state_next = S_A;
      endcase
      S_B: case (in_)
        2'b00:   state_next = S_C;
        2'b01:   state_next = S_B;
        2'b11:   state_next = S_E;
        default: state_next = S_A;
      endcase
      S_C: case (in_)
        2'b01:   state_next = S_D;
        2'b11:   state_next = S_E;
        default: state_next = S_A;
      endcase
      S_D: case (in_)
        2'b00:   state_next = S_C;
        2'b01:   state_next = S_B;
        2'b11:   state_next = S_E;
        default: state_next = S_A;
      endcase
      S_E: case (in_)
        2'b00,
        2'b01:   state_next = S_F;
        2'b11:   state_next = S_E;
        default: state_next = S_A;
      endcase
      default: state_next = S_A;
    endcase
  end

  always_comb begin
    out0 = 1'b0;
    out1 = 1'b0;
    unique case (1'b1)
      (state == S_D): begin
        out0 = 1'b1;
      end
      (state == S_E),
      (state == S_F): begin
        out0 = 1'b1;
        out1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_6s2i2o_mo_stepper.sv
// Stepper top: state register, load/step mux, err flag and
// optional saturating trans_count (FSM_STEPPER_CNT_EN).
module fsm_6s2i2o_mo_stepper
  import fsm_stepper_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               step_val,
  input  logic [1:0]         in_,
  input  logic               load_en,
  input  logic [STATE_W-1:0] load_state,
  output logic [STATE_W-1:0] state,
  output logic               out0,
  output logic               out1,
  output logic               out_val,
  output logic [7:0]         trans_count,
  output logic               err
);

  logic [STATE_W-1:0] state_next;
  logic               step_take;

  fsm_6s2i2o_mo_tbl_logic u_tbl (
    .state      (state),
    .in_        (in_),
    .state_next (state_next),
    .out0       (out0),
    .out1       (out1)
  );

  // load wins; a step presented alongside a load is dropped
  assign step_take = step_val & ~load_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      out_val <= 1'b0;
      err     <= 1'b0;
    end else begin
      out_val <= load_en | step_val;
      if (load_en)
        state <= load_state;
      else if (step_take)
        state <= state_next;
      if (load_en && is_invalid(load_state))
        err <= 1'b1;
    end
  end

`ifdef FSM_STEPPER_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= 8'd0;
    else if (step_take && state_next != state
             && cnt_q != 8'hff)
      cnt_q <= cnt_q + 8'd1;
  end

  assign trans_count = cnt_q;
`else
  assign trans_count = 8'd0;
`endif

endmodule

// File: tb/tb_fsm_6s2i2o_mo_stepper.sv
// Randomized and directed bench for fsm_6s2i2o_mo_stepper
// against a table-driven reference model.
module tb_fsm_6s2i2o_mo_stepper;

`ifdef FSM_STEPPER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       step_val;
  logic [1:0] in_;
  logic       load_en;
  logic [2:0] load_state;
  logic [2:0] state;
  logic       out0;
  logic       out1;
  logic       out_val;
  logic [7:0] trans_count;
  logic       err;

  fsm_6s2i2o_mo_stepper dut (
    .clk         (clk),
    .reset       (reset),
    .step_val    (step_val),
    .in_         (in_),
    .load_en     (load_en),
    .load_state  (load_state),
    .state       (state),
    .out0        (out0),
    .out1        (out1),
    .out_val     (out_val),
    .trans_count (trans_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  int nxt_tbl [0:5][0:3] = '{
    '{0, 1, 0, 4},
    '{2, 1, 0, 4},
    '{0, 3, 0, 4},
    '{2, 1, 0, 4},
    '{5, 5, 0, 4},
    '{0, 0, 0, 0}
  };

  int m_st;
  int m_cnt;
  int m_err;
  int m_ov;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_o0(input int s);
    return (s == 3 || s == 4 || s == 5) ? 1 : 0;
  endfunction

  function automatic int exp_o1(input int s);
    return (s == 4 || s == 5) ? 1 : 0;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, " state"}, 32'(state), 32'(m_st));
    chk({ctx, " out0"}, 32'(out0), 32'(exp_o0(m_st)));
    chk({ctx, " out1"}, 32'(out1), 32'(exp_o1(m_st)));
    chk({ctx, " out_val"}, 32'(out_val), 32'(m_ov));
    chk({ctx, " cnt"}, 32'(trans_count),
        CNT_EN ? 32'(m_cnt) : 32'd0);
    chk({ctx, " err"}, 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_cnt = 0;
    m_err = 0;
    m_ov  = 0;
  endtask

  task automatic cycle(input string ctx, input bit ld,
                       input int ls, input bit sv,
                       input int iv);
    int nx;
    load_en    = ld;
    load_state = 3'(ls);
    step_val   = sv;
    in_        = 2'(iv);
    @(posedge clk);
    if (ld) begin
      m_st = ls;
      m_ov = 1;
      if (ls >= 6) m_err = 1;
    end else if (sv) begin
      nx = (m_st >= 6) ? 0 : nxt_tbl[m_st][iv];
      if (nx != m_st && m_cnt < 255) m_cnt++;
      m_st = nx;
      m_ov = 1;
    end else begin
      m_ov = 0;
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    step_val   = 1'b0;
    in_        = 2'b00;
    load_en    = 1'b0;
    load_state = 3'd0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    cycle("seq1", 0, 0, 1, 1);
    cycle("seq2", 0, 0, 1, 0);
    cycle("seq3", 0, 0, 1, 1);
    chk("seq at D", 32'(m_st), 32'd3);
    cycle("idle", 0, 0, 0, 0);

    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 4; i++) begin
        cycle("sweep ld", 1, s, 0, 0);
        cycle($sformatf("sweep s%0d i%0d", s, i), 0, 0, 1, i);
      end
    end

    for (int b = 6; b < 8; b++) begin
      cycle($sformatf("inv ld%0d", b), 1, b, 0, 0);
      cycle($sformatf("inv hold%0d", b), 0, 0, 0, 0);
      cycle($sformatf("inv step%0d", b), 0, 0, 1, 3);
    end

    cycle("prio ldA", 1, 0, 0, 0);
    cycle("prio", 1, 4, 1, 1);

    for (int k = 0; k < 400; k++) begin
      cycle("rand",
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 7)),
            1'($urandom),
            int'($urandom_range(0, 3)));
    end

    cycle("sat ldA", 1, 0, 0, 0);
    for (int k = 0; k < 300; k++)
      cycle("sat", 0, 0, 1, (k % 2 == 0) ? 1 : 2);
    for (int k = 0; k < 4; k++)
      cycle("sat self", 0, 0, 1, 0);

    cycle("ar ldE", 1, 4, 0, 0);
    cycle("ar idle", 0, 0, 0, 0);
    load_en  = 1'b0;
    step_val = 1'b1;
    in_      = 2'b01;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async rst");
    @(posedge clk);
    #1;
    check_all("rst hold");
    @(negedge clk);
    reset = 1'b0;
    cycle("post rst", 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
